codec_dac_tx: RTL

//  Serializer feeding the audio codec DAC. Takes the processed stereo samples
//  (lft_out/rht_out, the same words driven to the LED level meter) through a
//  one-deep valid/ready buffer. Shifts them out left-justified, MSB first,

---
 rtl/codec_dac_tx.sv | 111 +++++++++++
 1 files changed

// File: rtl/codec_dac_tx.sv
// codec_dac_tx: left-justified stereo serializer for the codec DAC.
// One-deep sample buffer, internal MCLK/SCLK/LRCLK, repeat on underrun.
module codec_dac_tx #(
  parameter int DIV_LOG2 = 5,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDout,
  output logic              underrun
);

  localparam int CW = DIV_LOG2 + 5;
  localparam int FW = 2 * DATA_W;
  localparam logic [CW-1:0] PRE_END = {{(CW-1){1'b1}}, 1'b0};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   shift_reg;
  logic [FW-1:0]   last_frm;
  logic [FW-1:0]   hold;
  logic            full;
  logic            underrun_q;
  logic            frame_end;
  logic            bit_end;
  logic            acc;

  assign frame_end = &cnt;
  assign bit_end   = &cnt[DIV_LOG2-1:0];
  assign acc       = smpl_vld & ~full;

  assign smpl_rdy = ~full;
  assign MCLK     = cnt[1];
  assign SCLK     = cnt[DIV_LOG2-1];
  assign LRCLK    = cnt[DIV_LOG2+4];
  assign SDout    = shift_reg[FW-1];
  assign underrun = underrun_q;

  // Free-running frame counter; all codec clocks are taps of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CW'(1);
  end

  // Hold buffer: filled on handshake, drained by the frame load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      full <= 1'b0;
    end else if (acc) begin
      hold <= {lft_out, rht_out};
      full <= 1'b1;
    end else if (frame_end) begin
      full <= 1'b0;
    end
  end

  // Frame FSM: load or repeat at frame end, shift on SCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      last_frm  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_end && full) begin
            state     <= RUN;
            shift_reg <= hold;
            last_frm  <= hold;
          end
        end
        RUN: begin
          unique case (1'b1)
            frame_end && full: begin
              shift_reg <= hold;
              last_frm  <= hold;
            end
            frame_end && !full: begin
              shift_reg <= last_frm;
            end
            bit_end && !frame_end: begin
              shift_reg <= {shift_reg[FW-2:0], 1'b0};
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Underrun flag is high during the last clk of a frame that will repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_q <= 1'b0;
    else        underrun_q <= (state == RUN) && (cnt == PRE_END) && !(full || acc);
  end

endmodule
